crc16_frame_gen: RTL and testbench

//  Transmit-side companion of the 64-bit CRC16 frame checker: takes a 48-bit payload,

---
 rtl/crc16_frame_gen_if.sv | 22 ++
 rtl/crc16_frame_gen.sv | 110 +++++++++++
 tb/tb_crc16_frame_gen.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/crc16_frame_gen_if.sv
// Payload-in / frame-out handshake bundle for crc16_frame_gen.
// The slave modport is the generator's view; the master modport is the source/sink view.
interface crc16_frame_gen_if #(
  parameter int unsigned PAYLOAD_BYTES = 6
);
  logic [8*PAYLOAD_BYTES-1:0]  dataIn;
  logic                        inValid;
  logic                        inReady;
  logic [8*PAYLOAD_BYTES+15:0] frameOut;
  logic                        outValid;
  logic                        outReady;

  modport master (
    output dataIn, inValid, outReady,
    input  inReady, frameOut, outValid
  );

  modport slave (
    input  dataIn, inValid, outReady,
    output inReady, frameOut, outValid
  );
endinterface

// File: rtl/crc16_frame_gen.sv
// Byte-serial CRC16 frame generator: latches a payload, folds one byte per falling
// clock edge (MSB byte first), then presents {payload, crc16} until taken downstream.
module crc16_frame_gen #(
  parameter int unsigned PAYLOAD_BYTES = 6,
  parameter logic [15:0] POLY          = 16'h1021,
  parameter logic [15:0] INIT          = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic             crcBusy,
  output logic [3:0]       byteCnt,
  crc16_frame_gen_if.slave bus
);
  localparam int unsigned PW = 8 * PAYLOAD_BYTES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [PW-1:0]  payload_q;
  logic [PW-1:0]  payload_rot;
  logic [15:0]    crc_q;
  logic [15:0]    crc_d;
  logic [3:0]     byteCnt_q;
  logic [PW+15:0] frame_q;
  logic           inReady_q;
  logic           outValid_q;
  logic           crcBusy_q;
  logic           last_byte;

  // The payload register rotates left one byte per fold so the byte being folded is
  // always at the top; after PAYLOAD_BYTES rotations it is back in original order.
  always_comb begin
    payload_rot = (payload_q << 8) | (payload_q >> (PW - 8));
    last_byte   = (byteCnt_q == 4'(PAYLOAD_BYTES - 1));
    crc_d       = crc_q ^ {payload_q[PW-1 -: 8], 8'h00};
    for (int unsigned i = 0; i < 8; i++) begin
      crc_d = crc_d[15] ? ({crc_d[14:0], 1'b0} ^ POLY) : {crc_d[14:0], 1'b0};
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      payload_q  <= '0;
      crc_q      <= INIT;
      byteCnt_q  <= '0;
      frame_q    <= '0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      crcBusy_q  <= 1'b0;
    end else if (clr) begin
      state_q    <= IDLE;
      byteCnt_q  <= '0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      crcBusy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.inValid && inReady_q) begin
            payload_q <= bus.dataIn;
            crc_q     <= INIT;
            byteCnt_q <= '0;
            inReady_q <= 1'b0;
            crcBusy_q <= 1'b1;
            state_q   <= CALC;
          end
        end
        CALC: begin
          crc_q     <= crc_d;
          payload_q <= payload_rot;
          if (last_byte) begin
            frame_q    <= {payload_rot, crc_d};
            outValid_q <= 1'b1;
            crcBusy_q  <= 1'b0;
            byteCnt_q  <= '0;
            state_q    <= DONE;
          end else begin
            byteCnt_q <= byteCnt_q + 4'd1;
          end
        end
        DONE: begin
          if (outValid_q && bus.outReady) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          byteCnt_q  <= '0;
          inReady_q  <= 1'b1;
          outValid_q <= 1'b0;
          crcBusy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.inReady  = inReady_q;
  assign bus.outValid = outValid_q;
  assign bus.frameOut = frame_q;
  assign crcBusy      = crcBusy_q;
  assign byteCnt      = byteCnt_q;
endmodule

// File: tb/tb_crc16_frame_gen.sv
// Directed bench for crc16_frame_gen: default 6-byte instance plus 1-byte and 9-byte
// instances for the known-answer vectors; frames are scored against a bit-serial CRC model.
module tb_crc16_frame_gen;
  logic clk = 1'b0;
  logic rst;
  logic clr;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(negedge clk) cyc <= cyc + 1;

  crc16_frame_gen_if #(.PAYLOAD_BYTES(6)) m  ();
  crc16_frame_gen_if #(.PAYLOAD_BYTES(1)) s1 ();
  crc16_frame_gen_if #(.PAYLOAD_BYTES(9)) s9 ();

  logic       busy6, busy1, busy9;
  logic [3:0] cnt6, cnt1, cnt9;

  crc16_frame_gen #(.PAYLOAD_BYTES(6), .POLY(16'h1021), .INIT(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .clr(clr), .crcBusy(busy6), .byteCnt(cnt6), .bus(m));
  crc16_frame_gen #(.PAYLOAD_BYTES(1), .POLY(16'h1021), .INIT(16'hFFFF)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .crcBusy(busy1), .byteCnt(cnt1), .bus(s1));
  crc16_frame_gen #(.PAYLOAD_BYTES(9), .POLY(16'h1021), .INIT(16'hFFFF)) dut9 (
    .clk(clk), .rst(rst), .clr(clr), .crcBusy(busy9), .byteCnt(cnt9), .bus(s9));

  logic [63:0] sb_q[$];
  int          acc_q[$];

  function automatic logic [15:0] crc_model(input logic [127:0] d, input int nbits);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = nbits - 1; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a posedge with the main DUT idle; returns on the posedge after acceptance.
  task automatic send_main(input logic [47:0] p, input bit score);
    chk("send_inready", m.inReady, 1'b1);
    m.dataIn  = p;
    m.inValid = 1'b1;
    if (score) begin
      sb_q.push_back({p, crc_model({80'h0, p}, 48)});
      acc_q.push_back(cyc);
    end
    @(posedge clk);
    m.inValid = 1'b0;
  endtask

  task automatic wait_main_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (!m.outValid && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(tag, m.outValid, 1'b1);
  endtask

  task automatic pop_cmp(input string tag);
    logic [63:0] e;
    if (sb_q.size() == 0) e = 'x;
    else e = sb_q.pop_front();
    chk(tag, m.frameOut, e);
    chk({tag, "_residue"}, crc_model({64'h0, m.frameOut}, 64), 16'h0000);
  endtask

  initial begin
    logic [47:0] p;
    logic [63:0] held;
    int          sent, got, last_obs, t0, n;
    bit          rose;

    rst = 1'b1;
    clr = 1'b0;
    m.dataIn  = '0; m.inValid  = 1'b0; m.outReady  = 1'b0;
    s1.dataIn = '0; s1.inValid = 1'b0; s1.outReady = 1'b0;
    s9.dataIn = '0; s9.inValid = 1'b0; s9.outReady = 1'b0;

    @(posedge clk);
    chk("rst_inReady",  m.inReady,  1'b1);
    chk("rst_outValid", m.outValid, 1'b0);
    chk("rst_crcBusy",  busy6,      1'b0);
    chk("rst_byteCnt",  cnt6,       4'd0);
    chk("rst_frameOut", m.frameOut, 64'h0);
    rst = 1'b0;
    @(posedge clk);

    // 1-byte known answer: one edge from accept to outValid
    s1.dataIn = 8'h00; s1.inValid = 1'b1; s1.outReady = 1'b1;
    @(posedge clk);
    s1.inValid = 1'b0;
    chk("t1_inReady_drop", s1.inReady, 1'b0);
    chk("t1_busy", busy1, 1'b1);
    @(posedge clk);
    chk("t1_outValid", s1.outValid, 1'b1);
    chk("t1_frame", s1.frameOut, 24'h00E1F0);

    // 9-byte "123456789" known answer
    s9.dataIn = 72'h313233343536373839; s9.inValid = 1'b1; s9.outReady = 1'b1;
    t0 = cyc;
    @(posedge clk);
    s9.inValid = 1'b0;
    n = 0;
    while (!s9.outValid && n < 30) begin @(posedge clk); n++; end
    chk("t2_outValid", s9.outValid, 1'b1);
    chk("t2_latency", cyc - t0, 10);
    chk("t2_frame", s9.frameOut, {72'h313233343536373839, 16'h29B1});

    // back-to-back random frames, outReady tied high
    m.outReady = 1'b1;
    sent = 0; got = 0; last_obs = 0;
    for (int k = 0; k < 150 && got < 6; k++) begin
      if (m.outValid) begin
        pop_cmp("t3_frame");
        chk("t3_latency", cyc - acc_q.pop_front(), 7);
        if (got > 0) chk("t3_period", cyc - last_obs, 8);
        chk("t3_inReady_low", m.inReady, 1'b0);
        last_obs = cyc;
        got++;
      end
      if (m.inReady && sent < 6) begin
        p = 48'({$urandom(), $urandom()});
        m.dataIn  = p;
        m.inValid = 1'b1;
        sb_q.push_back({p, crc_model({80'h0, p}, 48)});
        acc_q.push_back(cyc);
        sent++;
      end else begin
        m.inValid = 1'b0;
      end
      @(posedge clk);
    end
    m.inValid = 1'b0;
    chk("t3_count", got, 6);
    acc_q.delete();
    @(posedge clk);

    // backpressure: hold DONE for 20 cycles with a competing payload offered
    m.outReady = 1'b0;
    p = 48'hDEAD_BEEF_0123;
    send_main(p, 1'b1);
    wait_main_valid("t4_valid_timeout", 20);
    held = m.frameOut;
    pop_cmp("t4_frame");
    m.dataIn = ~p; m.inValid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      chk("t4_hold_valid", m.outValid, 1'b1);
      chk("t4_hold_frame", m.frameOut, held);
      chk("t4_hold_inReady", m.inReady, 1'b0);
    end
    m.inValid = 1'b0; m.outReady = 1'b1;
    @(posedge clk);
    chk("t4_release_valid", m.outValid, 1'b0);
    chk("t4_release_inReady", m.inReady, 1'b1);
    @(posedge clk);
    chk("t4_no_ghost_busy", busy6, 1'b0);
    chk("t4_no_ghost_valid", m.outValid, 1'b0);

    // clr at byteCnt 3 aborts the frame; the next payload must start from INIT
    send_main(48'h1122_3344_5566, 1'b0);
    n = 0;
    while (cnt6 != 4'd3 && n < 10) begin @(posedge clk); n++; end
    chk("t5_reach_cnt3", cnt6, 4'd3);
    clr = 1'b1;
    @(posedge clk);
    clr = 1'b0;
    chk("t5_clr_inReady", m.inReady, 1'b1);
    chk("t5_clr_busy", busy6, 1'b0);
    chk("t5_clr_cnt", cnt6, 4'd0);
    rose = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (m.outValid) rose = 1'b1;
      @(posedge clk);
    end
    chk("t5_no_output", rose, 1'b0);
    send_main(48'hCAFE_F00D_7777, 1'b1);
    wait_main_valid("t5_valid_timeout", 20);
    pop_cmp("t5_frame");
    @(posedge clk);

    // asynchronous reset between edges mid-CALC
    send_main(48'hA5A5_5A5A_0F0F, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_inReady", m.inReady, 1'b1);
    chk("t6_rst_valid", m.outValid, 1'b0);
    chk("t6_rst_busy", busy6, 1'b0);
    chk("t6_rst_cnt", cnt6, 4'd0);
    chk("t6_rst_frame", m.frameOut, 64'h0);
    @(posedge clk);
    rst = 1'b0;
    @(posedge clk);
    chk("t6_post_valid", m.outValid, 1'b0);
    send_main(48'h0, 1'b1);
    wait_main_valid("t6_valid_timeout", 20);
    pop_cmp("t6_frame");
    chk("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
